// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 controller: opcodes, FSM states,
// datapath mux selects, ALU op codes and the packed control vector.
package multi_cycle_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int unsigned StateW = 4;

  typedef enum logic [StateW-1:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StMaddr = 4'd2,
    StMemRd = 4'd3,
    StMemWb = 4'd4,
    StMemWr = 4'd5,
    StExR   = 4'd6,
    StExI   = 4'd7,
    StAluWb = 4'd8,
    StBeq   = 4'd9,
    StJal   = 4'd10,
    StFault = 4'd11
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_JAL   = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       retire;
    logic       fault;
  } ctrl_t;

  // States that own the memory port and therefore wait on memReady.
  function automatic logic is_mem_state(state_e s);
    return s inside {StIf, StMemRd, StMemWr};
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: IR and memory handshake in, strobes and selects out.
interface multi_cycle_ctrl_if;
  import multi_cycle_ctrl_pkg::*;

  logic [31:0]       instruction;
  logic              memReady;
  logic              memReq;
  logic              memRead;
  logic              memWrite;
  logic              iorD;
  logic              irWrite;
  logic              pcWrite;
  logic              pcWriteCond;
  logic [1:0]        pcSource;
  logic [1:0]        aluSrcA;
  logic [1:0]        aluSrcB;
  logic [1:0]        aluOp;
  logic              regWrite;
  logic [1:0]        memToReg;
  logic              retire;
  logic              fault;
  logic [StateW-1:0] stateOut;

  modport master (
    input  instruction, memReady,
    output memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, pcSource,
           aluSrcA, aluSrcB, aluOp, regWrite, memToReg, retire, fault, stateOut
  );

  modport slave (
    output instruction, memReady,
    input  memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, pcSource,
           aluSrcA, aluSrcB, aluOp, regWrite, memToReg, retire, fault, stateOut
  );

endinterface

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational state -> control-vector lookup; memReady only qualifies the
// completing strobes of memory states.
module mc_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StIf: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_source = PCSRC_ALU;
      end
      // Branch/jump target is precomputed into ALUOut from oldPC + imm.
      StId: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      StMaddr, StExI: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      StMemRd: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_MDR;
        ctrl.retire     = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = mem_ready;
      end
      StExR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      StAluWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_ALUOUT;
        ctrl.retire     = 1'b1;
      end
      StBeq: begin
        ctrl.alu_src_a     = SRCA_A;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      StJal: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.alu_op     = ALU_JAL;
        ctrl.retire     = 1'b1;
      end
      StFault: ctrl.fault = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore sequencer for the shared multi-cycle RV32 datapath (lw, sw, add, addi, beq, jal)
// with a memory-wait watchdog that parks the core in StFault.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned STATE_W    = 4
) (
  input  logic               clk,
  input  logic               rstn,
  multi_cycle_ctrl_if.master bus
);

  localparam int unsigned CntW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [6:0]      opcode;
  logic            waiting;
  logic            timeout;
  ctrl_t           dec;
  ctrl_t           ctrl;

  assign opcode  = bus.instruction[6:0];
  assign waiting = is_mem_state(state_q) && !bus.memReady;
  assign timeout = (WAIT_LIMIT != 0) && waiting && (wait_cnt_q == CntW'(WAIT_LIMIT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIf;
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= (waiting && !timeout) ? wait_cnt_q + 1'b1 : '0;
      unique case (state_q)
        StIf: begin
          if (bus.memReady)  state_q <= StId;
          else if (timeout)  state_q <= StFault;
        end
        StId: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_q <= StMaddr;
            OP_R:              state_q <= StExR;
            OP_IMM:            state_q <= StExI;
            OP_BRANCH:         state_q <= StBeq;
            OP_JAL:            state_q <= StJal;
            default:           state_q <= StFault;
          endcase
        end
        StMaddr: state_q <= (opcode == OP_STORE) ? StMemWr : StMemRd;
        StMemRd: begin
          if (bus.memReady)  state_q <= StMemWb;
          else if (timeout)  state_q <= StFault;
        end
        StMemWr: begin
          if (bus.memReady)  state_q <= StIf;
          else if (timeout)  state_q <= StFault;
        end
        StExR, StExI:                 state_q <= StAluWb;
        StMemWb, StAluWb, StBeq, StJal: state_q <= StIf;
        StFault:                      state_q <= StFault;
        default:                      state_q <= StFault;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.memReady),
    .ctrl      (dec)
  );

  // Gating by rstn lets an abort drop memWrite without waiting for a clock edge.
  assign ctrl = rstn ? dec : '0;

  assign bus.memReq      = ctrl.mem_req;
  assign bus.memRead     = ctrl.mem_read;
  assign bus.memWrite    = ctrl.mem_write;
  assign bus.iorD        = ctrl.iord;
  assign bus.irWrite     = ctrl.ir_write;
  assign bus.pcWrite     = ctrl.pc_write;
  assign bus.pcWriteCond = ctrl.pc_write_cond;
  assign bus.pcSource    = ctrl.pc_source;
  assign bus.aluSrcA     = ctrl.alu_src_a;
  assign bus.aluSrcB     = ctrl.alu_src_b;
  assign bus.aluOp       = ctrl.alu_op;
  assign bus.regWrite    = ctrl.reg_write;
  assign bus.memToReg    = ctrl.mem_to_reg;
  assign bus.retire      = ctrl.retire;
  assign bus.fault       = ctrl.fault;
  assign bus.stateOut    = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: randomized instruction/stall stream with a
// phase-list reference model, plus directed timeout, illegal-opcode and reset cases.
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl #(
    .WAIT_LIMIT (15),
    .STATE_W    (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int cycles;
    int ir_writes;
    int pc_writes;
    int pc_conds;
    int reg_writes;
    int reg_at_retire;
    int mem_reads;
    int mem_writes;
    int iord_cycles;
  } instr_exp_t;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic       sb_en        = 1'b0;
  instr_exp_t exp_q[$];
  state_e     exp_state_q[$];
  state_e     stim_state_q[$];
  logic       stim_rdy_q[$];

  task automatic check(input string name, input int act, input int expv);
    tests_run++;
    if (act != expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int strobes_active();
    return int'(bus.memReq) + int'(bus.memRead) + int'(bus.memWrite) + int'(bus.iorD) +
           int'(bus.irWrite) + int'(bus.pcWrite) + int'(bus.pcWriteCond) +
           int'(bus.regWrite) + int'(bus.retire) + int'(bus.pcSource) + int'(bus.aluSrcA) +
           int'(bus.aluSrcB) + int'(bus.aluOp) + int'(bus.memToReg);
  endfunction

  // A memory phase is stall cycles with memReady low then one completing cycle.
  task automatic add_mem(input state_e s, input int stall);
    for (int i = 0; i <= stall; i++) begin
      stim_state_q.push_back(s);
      stim_rdy_q.push_back(i == stall);
    end
  endtask

  // memReady is irrelevant outside memory phases, so it is randomized there.
  task automatic add_plain(input state_e s);
    stim_state_q.push_back(s);
    stim_rdy_q.push_back(1'($urandom));
  endtask

  // Called at a negedge; returns at the negedge after the instruction's last cycle.
  task automatic run_instr(input logic [6:0] op, input int s_if, input int s_mem);
    instr_exp_t  e;
    logic [31:0] r;
    logic        is_lw, is_sw, writes_rf;
    stim_state_q.delete();
    stim_rdy_q.delete();
    add_mem(StIf, s_if);
    add_plain(StId);
    case (op)
      OP_LOAD:   begin add_plain(StMaddr); add_mem(StMemRd, s_mem); add_plain(StMemWb); end
      OP_STORE:  begin add_plain(StMaddr); add_mem(StMemWr, s_mem); end
      OP_R:      begin add_plain(StExR); add_plain(StAluWb); end
      OP_IMM:    begin add_plain(StExI); add_plain(StAluWb); end
      OP_BRANCH: add_plain(StBeq);
      default:   add_plain(StJal);
    endcase
    is_lw     = (op == OP_LOAD);
    is_sw     = (op == OP_STORE);
    writes_rf = is_lw || op == OP_R || op == OP_IMM || op == OP_JAL;
    e.cycles        = stim_state_q.size();
    e.ir_writes     = 1;
    e.pc_writes     = (op == OP_JAL) ? 2 : 1;
    e.pc_conds      = (op == OP_BRANCH) ? 1 : 0;
    e.reg_writes    = writes_rf ? 1 : 0;
    e.reg_at_retire = writes_rf ? 1 : 0;
    e.mem_reads     = s_if + 1 + (is_lw ? s_mem + 1 : 0);
    e.mem_writes    = is_sw ? s_mem + 1 : 0;
    e.iord_cycles   = (is_lw || is_sw) ? s_mem + 1 : 0;
    exp_q.push_back(e);
    foreach (stim_state_q[i]) exp_state_q.push_back(stim_state_q[i]);
    r = $urandom();
    bus.instruction = {r[31:7], op};
    foreach (stim_rdy_q[i]) begin
      bus.memReady = stim_rdy_q[i];
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: per-cycle state check, per-instruction totals compared at each retire.
  int acc_cyc = 0, acc_ir = 0, acc_pcw = 0, acc_pcc = 0, acc_rw = 0;
  int acc_rd = 0, acc_wr = 0, acc_iord = 0;
  initial begin
    instr_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_en) begin
        if (exp_state_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_cycle: got state %0d, expected no activity", bus.stateOut);
        end else begin
          check("state", int'(bus.stateOut), int'(exp_state_q.pop_front()));
        end
        acc_cyc++;
        acc_ir   += int'(bus.irWrite);
        acc_pcw  += int'(bus.pcWrite);
        acc_pcc  += int'(bus.pcWriteCond);
        acc_rw   += int'(bus.regWrite);
        acc_rd   += int'(bus.memRead);
        acc_wr   += int'(bus.memWrite);
        acc_iord += int'(bus.iorD);
        if (bus.retire) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_retire: got retire, expected none");
          end else begin
            e = exp_q.pop_front();
            check("cycles", acc_cyc, e.cycles);
            check("ir_writes", acc_ir, e.ir_writes);
            check("pc_writes", acc_pcw, e.pc_writes);
            check("pc_write_cond", acc_pcc, e.pc_conds);
            check("reg_writes", acc_rw, e.reg_writes);
            check("reg_write_at_retire", int'(bus.regWrite), e.reg_at_retire);
            check("mem_read_cycles", acc_rd, e.mem_reads);
            check("mem_write_cycles", acc_wr, e.mem_writes);
            check("iord_cycles", acc_iord, e.iord_cycles);
          end
          acc_cyc = 0; acc_ir = 0; acc_pcw = 0; acc_pcc = 0;
          acc_rw  = 0; acc_rd = 0; acc_wr  = 0; acc_iord = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "time limit");
  end

  logic [6:0] ops [6];
  logic [31:0] r;

  initial begin
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH, OP_JAL};
    rstn            = 1'b0;
    bus.memReady    = 1'b1;
    bus.instruction = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_strobes", strobes_active(), 0);
    check("reset_fault", int'(bus.fault), 0);
    check("reset_state", int'(bus.stateOut), int'(StIf));

    @(negedge clk);
    rstn  = 1'b1;
    sb_en = 1'b1;
    run_instr(OP_LOAD, 0, 0);
    run_instr(OP_R, 0, 0);
    run_instr(OP_IMM, 0, 0);
    run_instr(OP_BRANCH, 0, 0);
    run_instr(OP_JAL, 0, 0);
    run_instr(OP_STORE, 0, 0);
    run_instr(OP_R, 3, 0);
    run_instr(OP_LOAD, 15, 15);
    run_instr(OP_STORE, 2, 15);
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 4), $urandom_range(0, 4));
    end
    sb_en = 1'b0;
    check("pending_instr", exp_q.size(), 0);
    check("pending_cycles", exp_state_q.size(), 0);

    // lw whose data access never completes: 16 low cycles in MEM_RD trip the watchdog.
    pulse_reset();
    r = $urandom();
    bus.instruction = {r[31:7], OP_LOAD};
    bus.memReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus.memReady = 1'b0;
      #2;
      check("timeout_wait_state", int'(bus.stateOut), int'(StMemRd));
      check("timeout_wait_regwrite", int'(bus.regWrite), 0);
      @(negedge clk);
    end
    #2;
    check("timeout_state", int'(bus.stateOut), int'(StFault));
    check("timeout_fault", int'(bus.fault), 1);
    check("timeout_strobes", strobes_active(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.memReady = 1'b1;
      #2;
      check("fault_absorbing", int'(bus.fault), 1);
      check("fault_strobes", strobes_active(), 0);
    end

    // Illegal opcode goes ID -> FAULT and stays there until reset.
    @(negedge clk);
    pulse_reset();
    r = $urandom();
    bus.instruction = {r[31:7], 7'b1110011};
    bus.memReady = 1'b1;
    #2;
    check("illegal_if", int'(bus.stateOut), int'(StIf));
    @(negedge clk);
    #2;
    check("illegal_id", int'(bus.stateOut), int'(StId));
    @(negedge clk);
    #2;
    check("illegal_fault_state", int'(bus.stateOut), int'(StFault));
    check("illegal_fault", int'(bus.fault), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.memReady = 1'($urandom);
      #2;
      check("illegal_strobes", strobes_active(), 0);
    end
    @(negedge clk);
    pulse_reset();
    bus.memReady = 1'b1;
    r = $urandom();
    bus.instruction = {r[31:7], OP_STORE};
    #2;
    check("recover_state", int'(bus.stateOut), int'(StIf));
    check("recover_fault", int'(bus.fault), 0);

    // Reset while a store waits in MEM_WR drops memWrite immediately.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.memReady = 1'b0;
    #2;
    check("sw_wait_state", int'(bus.stateOut), int'(StMemWr));
    check("sw_wait_memwrite", int'(bus.memWrite), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_memwrite", int'(bus.memWrite), 0);
    check("abort_strobes", strobes_active(), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.memReady = 1'b0;
      #2;
      check("post_abort_if", int'(bus.stateOut), int'(StIf));
      @(negedge clk);
    end
    bus.memReady = 1'b1;
    #2;
    check("post_abort_irwrite", int'(bus.irWrite), 1);
    @(negedge clk);
    #2;
    check("post_abort_id", int'(bus.stateOut), int'(StId));
    check("post_abort_fault", int'(bus.fault), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
